avalon_alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_div.sv | 69 ++++++
 rtl/avalon_alu_seq.sv | 217 +++++++++++++++++++++
 tb/tb_avalon_alu_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential Avalon-MM ALU peripheral.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_AND = 4'd6,
        OP_OR  = 4'd7,
        OP_XOR = 4'd8
    } opcode_t;

    localparam logic [2:0] ADDR_OPA    = 3'd0;
    localparam logic [2:0] ADDR_OPB    = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd5;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_DBZ     = 2;
    localparam int ST_BAD_ACC = 3;
    localparam int ST_BAD_OP  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider: one quotient bit per cycle, DATA_W cycles per divide.
module alu_seq_div #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_last,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_div;

    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_trial;
    logic              w_qbit;
    logic [DATA_W-1:0] w_rem_next;

    // The dividend shifts out of r_quo's MSB while quotient bits shift in at the LSB.
    assign w_shift    = {r_rem, r_quo[DATA_W-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_qbit     = ~w_trial[DATA_W];
    assign w_rem_next = w_qbit ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_busy <= 1'b1;
                r_cnt  <= CNT_W'(DATA_W);
                r_quo  <= i_dividend;
                r_rem  <= '0;
                r_div  <= i_divisor;
            end else if (r_busy) begin
                r_quo <= {r_quo[DATA_W-2:0], w_qbit};
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_last      = r_busy && (r_cnt == CNT_W'(1));
    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/avalon_alu_seq.sv
// Avalon-MM ALU coprocessor: register file, control FSM, single-cycle ops and read path.
// Build option ALU_IRQ_EN adds the irq output and the IRQ_EN register at address 5.
module avalon_alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int SHAMT_W = $clog2(DATA_W),
    localparam int BUS_W   = 2 * DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       avs_address,
    input  logic [BUS_W-1:0] avs_write_data,
    input  logic             avs_write,
    input  logic             avs_read,
    output logic [BUS_W-1:0] avs_read_data,
`ifdef ALU_IRQ_EN
    output logic             irq,
`endif
    output logic             avs_readdatavalid
);

    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W[DATA_W-1:0];

    state_t            r_state;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_wa;
    logic [DATA_W-1:0] r_wb;
    logic [3:0]        r_wop;
    logic [BUS_W-1:0]  r_result;
    logic              r_done;
    logic              r_dbz;
    logic              r_bad_acc;
    logic              r_bad_op;
    logic [BUS_W-1:0]  r_rdata;
    logic              r_rvalid;
`ifdef ALU_IRQ_EN
    logic [1:0]        r_irq_en;
    logic              r_irq;
`endif

    logic              w_busy;
    logic              w_wr_ctrl;
    logic              w_start;
    logic              w_div_go;
    logic              w_unmapped;
    logic              w_bad_wr;
    logic [3:0]        w_w1c;
    logic              w_set_done;
    logic              w_set_dbz;
    logic              w_set_bad_op;
    logic              w_done_next;
    logic              w_dbz_next;
    logic              w_bad_acc_next;
    logic              w_bad_op_next;
    logic [BUS_W-1:0]  w_exec_result;
    logic [BUS_W-1:0]  w_rdata;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W-1:0] w_shl;
    logic [DATA_W-1:0] w_shr;
    logic              w_shift_ok;
    logic              w_div_last;
    logic              w_div_done;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;
    logic              w_unused_wdata;

    assign w_busy     = (r_state != S_IDLE);
    assign w_wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign w_start    = w_wr_ctrl && !w_busy;
    assign w_div_go   = w_start && (avs_write_data[3:0] == OP_DIV) && (r_opb != '0);
`ifdef ALU_IRQ_EN
    assign w_unmapped = (avs_address == 3'd6) || (avs_address == 3'd7);
`else
    assign w_unmapped = (avs_address == ADDR_IRQ_EN) || (avs_address == 3'd6) || (avs_address == 3'd7);
`endif
    assign w_bad_wr   = (avs_write && w_unmapped) || (w_wr_ctrl && w_busy);
    assign w_w1c      = (avs_write && avs_address == ADDR_STATUS) ? avs_write_data[4:1] : 4'b0;

    assign w_set_done   = (r_state == S_EXEC) || ((r_state == S_FIN) && w_div_done);
    assign w_set_dbz    = (r_state == S_EXEC) && (r_wop == OP_DIV);
    assign w_set_bad_op = (r_state == S_EXEC) && (r_wop > 4'd8);

    // Hardware sets win over a same-cycle W1C; a fresh start clears done.
    assign w_done_next    = w_set_done ? 1'b1 : (w_start ? 1'b0 : (r_done & ~w_w1c[0]));
    assign w_dbz_next     = w_set_dbz | (r_dbz & ~w_w1c[1]);
    assign w_bad_acc_next = w_bad_wr | (r_bad_acc & ~w_w1c[2]);
    assign w_bad_op_next  = w_set_bad_op | (r_bad_op & ~w_w1c[3]);

    assign w_sub      = {1'b0, r_wa} - {1'b0, r_wb};
    assign w_shift_ok = (r_wb < SHIFT_LIMIT);
    assign w_shl      = r_wa << r_wb[SHAMT_W-1:0];
    assign w_shr      = r_wa >> r_wb[SHAMT_W-1:0];

    assign w_unused_wdata = ^avs_write_data[BUS_W-1:DATA_W];

    always_comb begin
        w_exec_result = '0;
        case (r_wop)
            OP_ADD: w_exec_result = BUS_W'(r_wa) + BUS_W'(r_wb);
            OP_SUB: w_exec_result = BUS_W'(w_sub);
            OP_MUL: w_exec_result = BUS_W'(r_wa) * BUS_W'(r_wb);
            OP_DIV: w_exec_result = {r_wa, {DATA_W{1'b1}}};
            OP_SHL: w_exec_result = w_shift_ok ? BUS_W'(w_shl) : '0;
            OP_SHR: w_exec_result = w_shift_ok ? BUS_W'(w_shr) : '0;
            OP_AND: w_exec_result = BUS_W'(r_wa & r_wb);
            OP_OR:  w_exec_result = BUS_W'(r_wa | r_wb);
            OP_XOR: w_exec_result = BUS_W'(r_wa ^ r_wb);
            default: w_exec_result = '0;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            ADDR_OPA:    w_rdata = BUS_W'(r_opa);
            ADDR_OPB:    w_rdata = BUS_W'(r_opb);
            ADDR_CTRL:   w_rdata = BUS_W'(r_op);
            ADDR_STATUS: w_rdata = BUS_W'({r_bad_op, r_bad_acc, r_dbz, r_done, w_busy});
            ADDR_RESULT: w_rdata = r_result;
`ifdef ALU_IRQ_EN
            ADDR_IRQ_EN: w_rdata = BUS_W'(r_irq_en);
`endif
            default:     w_rdata = '0;
        endcase
    end

    alu_seq_div #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_div_go),
        .i_dividend  (r_opa),
        .i_divisor   (r_opb),
        .o_last      (w_div_last),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_opa     <= '0;
            r_opb     <= '0;
            r_op      <= '0;
            r_wa      <= '0;
            r_wb      <= '0;
            r_wop     <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_bad_acc <= 1'b0;
            r_bad_op  <= 1'b0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
`ifdef ALU_IRQ_EN
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
`endif
        end else begin
            r_done    <= w_done_next;
            r_dbz     <= w_dbz_next;
            r_bad_acc <= w_bad_acc_next;
            r_bad_op  <= w_bad_op_next;
            r_rvalid  <= avs_read;
            if (avs_read)
                r_rdata <= w_rdata;
            if (avs_write && avs_address == ADDR_OPA)
                r_opa <= avs_write_data[DATA_W-1:0];
            if (avs_write && avs_address == ADDR_OPB)
                r_opb <= avs_write_data[DATA_W-1:0];
`ifdef ALU_IRQ_EN
            if (avs_write && avs_address == ADDR_IRQ_EN)
                r_irq_en <= avs_write_data[1:0];
            r_irq <= (w_done_next & r_irq_en[0])
                   | ((w_dbz_next | w_bad_acc_next | w_bad_op_next) & r_irq_en[1]);
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_op    <= avs_write_data[3:0];
                        r_wop   <= avs_write_data[3:0];
                        r_wa    <= r_opa;
                        r_wb    <= r_opb;
                        r_state <= w_div_go ? S_DIV : S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= w_exec_result;
                    r_state  <= S_IDLE;
                end
                S_DIV: begin
                    if (w_div_last)
                        r_state <= S_FIN;
                end
                S_FIN: begin
                    if (w_div_done) begin
                        r_result <= {w_rem, w_quo};
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign avs_read_data     = r_rdata;
    assign avs_readdatavalid = r_rvalid;
`ifdef ALU_IRQ_EN
    assign irq               = r_irq;
`endif

endmodule

// File: tb/tb_avalon_alu_seq.sv
// Directed bench for avalon_alu_seq (DATA_W=16); irq checks compile only with ALU_IRQ_EN.
module tb_avalon_alu_seq;

    localparam int DATA_W = 16;
    localparam int BUS_W  = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       avs_address = '0;
    logic [BUS_W-1:0] avs_write_data = '0;
    logic             avs_write = 1'b0;
    logic             avs_read = 1'b0;
    logic [BUS_W-1:0] avs_read_data;
    logic             avs_readdatavalid;
`ifdef ALU_IRQ_EN
    logic             irq;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    avalon_alu_seq #(.DATA_W(DATA_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .avs_address       (avs_address),
        .avs_write_data    (avs_write_data),
        .avs_write         (avs_write),
        .avs_read          (avs_read),
        .avs_read_data     (avs_read_data),
`ifdef ALU_IRQ_EN
        .irq               (irq),
`endif
        .avs_readdatavalid (avs_readdatavalid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [2:0] addr, input logic [BUS_W-1:0] data);
        avs_address    = addr;
        avs_write_data = data;
        avs_write      = 1'b1;
        @(negedge clk);
        avs_write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [BUS_W-1:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_read_data;
        if (avs_readdatavalid !== 1'b1) begin
            n_fails++;
            $display("FAIL readdatavalid: got %b expected 1", avs_readdatavalid);
        end
    endtask

    task automatic read_check(input string tag, input logic [2:0] addr, input logic [BUS_W-1:0] exp);
        logic [BUS_W-1:0] d;
        bus_read(addr, d);
        check(tag, 64'(d), 64'(exp));
    endtask

    // Poll STATUS until not busy; returns number of reads taken.
    task automatic wait_idle(input string tag, output int reads);
        logic [BUS_W-1:0] d;
        reads = 0;
        d = 32'h1;
        while (d[0] && reads < 100) begin
            bus_read(3'd3, d);
            reads++;
        end
        check({tag, "_idle"}, 64'(d[0]), 64'h0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [BUS_W-1:0] exp);
        int n;
        bus_write(3'd2, {28'h0, op});
        wait_idle(tag, n);
        read_check(tag, 3'd4, exp);
    endtask

    initial begin
        logic [BUS_W-1:0] d;
        int n;

        #1;
        check("rst_rdata", 64'(avs_read_data), 64'h0);
        check("rst_rvalid", 64'(avs_readdatavalid), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        read_check("rst_status", 3'd3, 32'h0);
        read_check("rst_result", 3'd4, 32'h0);
        @(negedge clk);
        check("rvalid_pulse", 64'(avs_readdatavalid), 64'h0);

        // Same-cycle read and write of OPA returns the old value.
        avs_address = 3'd0; avs_write_data = 32'hABCD_1234;
        avs_write = 1'b1; avs_read = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        check("rw_same_opa", 64'(avs_read_data), 64'h0);
        read_check("opa_trunc", 3'd0, 32'h0000_1234);

        // Add with exact latency.
        bus_write(3'd0, 32'hFFFF);
        bus_write(3'd1, 32'h1);
        bus_write(3'd2, 32'h0);
        read_check("add_t1_status", 3'd3, 32'h1);
        read_check("add_t2_status", 3'd3, 32'h2);
        read_check("add_result", 3'd4, 32'h0001_0000);
        read_check("add_status", 3'd3, 32'h2);

        // Divide 1000/7: first idle STATUS read is the (DATA_W+2)th.
        bus_write(3'd0, 32'd1000);
        bus_write(3'd1, 32'd7);
        bus_write(3'd2, 32'h3);
        wait_idle("div", n);
        check("div_latency", 64'(n), 64'(DATA_W + 2));
        read_check("div_result", 3'd4, 32'h0006_008E);
        read_check("div_status", 3'd3, 32'h2);

        // Divide by zero; the new start clears done at t+1.
        bus_write(3'd1, 32'h0);
        bus_write(3'd2, 32'h3);
        read_check("dbz_t1_status", 3'd3, 32'h1);
        read_check("dbz_t2_status", 3'd3, 32'h6);
        read_check("dbz_result", 3'd4, 32'h03E8_FFFF);
        bus_write(3'd3, 32'h6);
        read_check("dbz_w1c", 3'd3, 32'h0);

        // CTRL write while dividing; OPA rewrite must not disturb the divide.
        bus_write(3'd1, 32'd7);
        bus_write(3'd2, 32'h3);
        @(negedge clk);
        @(negedge clk);
        bus_write(3'd2, 32'h2);
        bus_write(3'd0, 32'd5);
        wait_idle("busy_ctrl", n);
        read_check("busy_ctrl_result", 3'd4, 32'h0006_008E);
        read_check("busy_ctrl_status", 3'd3, 32'hA);
        read_check("busy_ctrl_op", 3'd2, 32'h3);
        bus_write(3'd3, 32'h8);
        read_check("bad_acc_w1c", 3'd3, 32'h2);

        // Shifts, including the out-of-range amount.
        bus_write(3'd0, 32'h1);
        bus_write(3'd1, 32'd16);
        run_op("shl_16", 4'd4, 32'h0);
        bus_write(3'd1, 32'd3);
        run_op("shl_3", 4'd4, 32'h8);
        bus_write(3'd1, 32'd15);
        run_op("shl_15", 4'd4, 32'h8000);
        bus_write(3'd0, 32'h8000);
        run_op("shr_15", 4'd5, 32'h1);

        // Sub with borrow, full-width mul, logic ops.
        bus_write(3'd0, 32'd3);
        bus_write(3'd1, 32'd5);
        run_op("sub_borrow", 4'd1, 32'h0001_FFFE);
        bus_write(3'd0, 32'hFFFF);
        bus_write(3'd1, 32'hFFFF);
        run_op("mul_max", 4'd2, 32'hFFFE_0001);
        bus_write(3'd0, 32'hF0F0);
        bus_write(3'd1, 32'hFF00);
        run_op("and", 4'd6, 32'hF000);
        run_op("or", 4'd7, 32'hFFF0);
        run_op("xor", 4'd8, 32'h0FF0);

        // Illegal opcode.
        run_op("bad_op", 4'd9, 32'h0);
        read_check("bad_op_status", 3'd3, 32'h12);
        bus_write(3'd3, 32'h1E);
        read_check("clear_all", 3'd3, 32'h0);

        // Unmapped accesses.
        bus_write(3'd6, 32'h1);
        read_check("unmapped_wr", 3'd3, 32'h8);
        read_check("unmapped_rd", 3'd7, 32'h0);
        bus_write(3'd3, 32'h8);
`ifndef ALU_IRQ_EN
        bus_write(3'd5, 32'h1);
        read_check("irq_en_unmapped", 3'd3, 32'h8);
        read_check("irq_en_rd0", 3'd5, 32'h0);
        bus_write(3'd3, 32'h8);
`endif

        // W1C of done in the cycle the EXEC state sets it: set wins.
        run_op("pre_and", 4'd6, 32'hF000);
        bus_write(3'd2, 32'h7);
        bus_write(3'd3, 32'h2);
        read_check("w1c_vs_set", 3'd3, 32'h2);

`ifdef ALU_IRQ_EN
        bus_write(3'd3, 32'h1E);
        bus_write(3'd5, 32'h1);
        read_check("irq_en_rd", 3'd5, 32'h1);
        bus_write(3'd2, 32'h2);
        check("irq_t1", 64'(irq), 64'h0);
        @(negedge clk);
        check("irq_t2", 64'(irq), 64'h1);
        bus_write(3'd3, 32'h2);
        check("irq_clear", 64'(irq), 64'h0);
        bus_write(3'd5, 32'h2);
        bus_write(3'd7, 32'h0);
        check("irq_err", 64'(irq), 64'h1);
        bus_write(3'd3, 32'h8);
        check("irq_err_clear", 64'(irq), 64'h0);
`endif

        // Reset in the middle of a divide.
        bus_write(3'd0, 32'd1000);
        bus_write(3'd1, 32'd7);
        bus_write(3'd2, 32'h3);
        read_check("pre_rst_status", 3'd3, 32'h1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rdata", 64'(avs_read_data), 64'h0);
        check("midrst_rvalid", 64'(avs_readdatavalid), 64'h0);
`ifdef ALU_IRQ_EN
        check("midrst_irq", 64'(irq), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("midrst_status", 3'd3, 32'h0);
        read_check("midrst_result", 3'd4, 32'h0);
        read_check("midrst_opa", 3'd0, 32'h0);
        repeat (DATA_W + 4) @(negedge clk);
        read_check("midrst_quiet", 3'd3, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
